mash_nc_stage: RTL and testbench
================================

# mash_nc_stage

Second-order MASH 1-1 error-shaping and noise-cancellation stage of the sigma-delta DAC. It sits directly downstream of the 3-bit truncator. It consumes the truncator's coarse sample and 13-bit truncation residue, and runs the residue through two cascaded first-order accumulators. It then recombines their carries with the coarse sample through a (1−z⁻¹) cancellation network, producing a 4-bit signed code for the unary/thermometer DAC driver.

## Interface
- `EW`, default 13: residue width from the truncator.
- `YW`, default 3: coarse sample width; the output is `YW+1` bits.
- `DITHER`, default 1: when 1, LFSR LSB dither is injected into accumulator 1; when 0, no dither.
- `clck`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: sample strobe; state advances only on cycles with `en=1`.
- `y_in`  in  YW, signed: coarse sample from the truncator.
- `e_in`  in  EW, unsigned: truncation residue (0 … 2^EW−1).
- `y_out`  out  YW+1, signed: noise-shaped output code.
- `valid_out`  out  1: one-cycle pulse marking a new `y_out`.

## Operation
- State registers:
  - `acc1`, `acc2` (EW bits, unsigned).
  - `c2_prev` (1 bit).
  - `lfsr` (16 bits): seed 16'hACE1, taps x^16+x^14+x^13+x^11+1, Fibonacci shift left, new bit into [0].
- Per `en` cycle (sample k), combinational:
  - `d = DITHER ? lfsr[0] : 0`.
  - `s1 = acc1 + e_in + d`, EW+1 bits; `c1 = s1[EW]`, `r1 = s1[EW-1:0]`.
  - `s2 = acc2 + r1`, EW+1 bits; `c2 = s2[EW]`, `r2 = s2[EW-1:0]`.
  - `corr = c1 + c2 − c2_prev`, range −1 … +2, 3-bit signed.
  - `sum = sext(y_in) + corr`, range −5 … +5; fits YW+1 bits, so no saturation is needed.
- On the rising edge with `en=1`:
  - `acc1<=r1`, `acc2<=r2`, `c2_prev<=c2`.
  - `lfsr` advances.
  - `y_out<=sum`, `valid_out<=1`.
- On an edge with `en=0`:
  - All state and `y_out` hold.
  - `valid_out<=0`.
- Accumulator wrap-around is modulo 2^EW by construction; the carry is the only overflow signal.
- Transfer function: y = y_in + e_in/2^EW + (1−z⁻¹)²·E2. The mean of `y_out` over many samples equals `y_in + e_in/2^EW`.

## Timing
- Reset (`rst=0`, asynchronous, takes effect immediately):
  - `acc1=acc2=0`, `c2_prev=0`, `lfsr=16'hACE1`.
  - `y_out=0`, `valid_out=0`.
- Release is synchronous-safe; the first `en` edge after release processes sample 0 from the clean state.
- Latency: `y_out` for sample k is visible one `clck` after the `en` edge that sampled `y_in[k]`/`e_in[k]`. `valid_out` is high for exactly that one cycle.
- Back-to-back `en` (every cycle) is supported at full rate, with no bubbles.
- `en` held low: outputs frozen, `valid_out` low, LFSR frozen (the dither sequence is sample-indexed, not cycle-indexed).
- Reset asserted mid-stream: all state clears in the same cycle, and any in-flight sample is discarded; no partial update survives.
- `y_in`/`e_in` are sampled only on `en` edges; their values at other times are don't-care.

## Structure
- Shared DAC package holds:
  - `EW`/`YW` defaults.
  - The LFSR seed and tap mask.
  - The output code type (`YW+1` signed), shared with the DAC driver.
- One sub-module is natural: `mash_acc1`, a first-order accumulator with carry-in (dither), carry-out and residue, instantiated twice. The second instance has its carry-in tied to 0.
- Cancellation network, output register and LFSR stay in the top module.

## Test plan
- Reset: hold `rst=0` for 3 cycles with random inputs → `y_out=0`, `valid_out=0`. After release, the first `en` with `y_in=0`, `e_in=0` gives `y_out=0`.
- Pure coarse path: `DITHER=0`, `e_in=0`, `y_in=3`, then `y_in=−4`, `en` every cycle → `y_out=3`, then `−4` one cycle later; `corr` is always 0.
- Half residue: `DITHER=0`, `y_in=0`, `e_in=4096`, continuous `en` → `y_out` sequence 0,1,1,0 repeating. The mean over 64 samples is exactly 0.5.
- Range extremes: `DITHER=0`, `y_in=3`, `e_in=8191` for 1024 samples → `y_out` always in 2 … 5 and never wraps negative. `y_in=−4`, `e_in=0` → constant −4.
- Strobe gating: `e_in=4096`, `en` asserted every third cycle → the same 0,1,1,0 sequence on the `valid_out` cycles. `y_out` holds between strobes, and `valid_out` is exactly one cycle wide.
- Mid-stream reset and dither:
  - `DITHER=1`, `e_in=4096` for 10 samples, pulse `rst=0` mid-cycle → all outputs clear asynchronously.
  - Replaying the same 10 samples reproduces a bit-identical `y_out` sequence, which confirms the LFSR reseed.

Source files
------------

// File: rtl/mash_nc_stage_pkg.sv
// Shared sigma-delta DAC definitions: default widths, dither LFSR constants and the
// output code type consumed by the unary DAC driver.
package mash_nc_stage_pkg;

  localparam int EW_DEF = 13;
  localparam int YW_DEF = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16+x^14+x^13+x^11+1, shifted left with the new bit entering at [0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic signed [YW_DEF:0] dac_code_t;

  function automatic logic [15:0] lfsrNext(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mash_nc_stage_if.sv
// Sample bus between the truncator, the MASH stage and the DAC driver.
interface mash_nc_stage_if
  import mash_nc_stage_pkg::*;
#(
  parameter int EW = EW_DEF,
  parameter int YW = YW_DEF
) ();

  logic                 en;
  logic signed [YW-1:0] y_in;
  logic        [EW-1:0] e_in;
  logic signed [YW:0]   y_out;
  logic                 valid_out;

  modport master (output en, output y_in, output e_in, input y_out, input valid_out);
  modport slave  (input en, input y_in, input e_in, output y_out, output valid_out);

endinterface

// File: rtl/mash_acc1.sv
// First-order error-feedback accumulator: adds the addend plus a carry-in modulo 2^EW and
// exposes the carry-out and the new residue combinationally for chaining.
module mash_acc1
  import mash_nc_stage_pkg::*;
#(
  parameter int EW = EW_DEF
) (
  input  logic          clck,
  input  logic          rst,
  input  logic          i_en,
  input  logic [EW-1:0] i_addend,
  input  logic          i_cin,
  output logic          o_carry,
  output logic [EW-1:0] o_res
);

  logic [EW-1:0] r_acc;
  logic [EW:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, i_addend} + {{EW{1'b0}}, i_cin};
  assign o_carry = w_sum[EW];
  assign o_res   = w_sum[EW-1:0];

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum[EW-1:0];
    end
  end

endmodule

// File: rtl/mash_nc_stage.sv
// MASH 1-1 stage: two cascaded accumulators shape the truncation residue and their carries
// are recombined with the coarse sample through a (1 - z^-1) cancellation network.
module mash_nc_stage
  import mash_nc_stage_pkg::*;
#(
  parameter int EW     = EW_DEF,
  parameter int YW     = YW_DEF,
  parameter bit DITHER = 1'b1
) (
  input logic           clck,
  input logic           rst,
  mash_nc_stage_if.slave bus
);

  logic                 w_dither;
  logic                 w_c1;
  logic                 w_c2;
  logic [EW-1:0]        w_r1;
  logic [EW-1:0]        w_unusedRes2;
  logic signed [2:0]    w_corr;
  logic signed [YW:0]   w_sum;

  logic                 r_c2Prev;
  logic [15:0]          r_lfsr;
  logic signed [YW:0]   r_yOut;
  logic                 r_valid;

  assign w_dither = DITHER ? r_lfsr[0] : 1'b0;

  mash_acc1 #(.EW(EW)) u_acc1 (
    .clck     (clck),
    .rst      (rst),
    .i_en     (bus.en),
    .i_addend (bus.e_in),
    .i_cin    (w_dither),
    .o_carry  (w_c1),
    .o_res    (w_r1)
  );

  mash_acc1 #(.EW(EW)) u_acc2 (
    .clck     (clck),
    .rst      (rst),
    .i_en     (bus.en),
    .i_addend (w_r1),
    .i_cin    (1'b0),
    .o_carry  (w_c2),
    .o_res    (w_unusedRes2)
  );

  // Correction spans -1..+2, so the sum with a YW-bit sample always fits YW+1 bits
  assign w_corr = $signed({2'b00, w_c1}) + $signed({2'b00, w_c2}) - $signed({2'b00, r_c2Prev});
  assign w_sum  = $signed({bus.y_in[YW-1], bus.y_in}) + $signed({{(YW-2){w_corr[2]}}, w_corr});

  // The LFSR steps only on strobes so the dither pattern is indexed by sample, not cycle
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      r_c2Prev <= 1'b0;
      r_lfsr   <= LFSR_SEED;
      r_yOut   <= '0;
      r_valid  <= 1'b0;
    end else if (bus.en) begin
      r_c2Prev <= w_c2;
      r_lfsr   <= lfsrNext(r_lfsr);
      r_yOut   <= w_sum;
      r_valid  <= 1'b1;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.y_out     = r_yOut;
  assign bus.valid_out = r_valid;

endmodule

// File: tb/tb_mash_nc_stage.sv
// Bench for mash_nc_stage: an undithered and a dithered instance share one stimulus stream
// and are compared every cycle against an integer-arithmetic model of the MASH recurrence.
module tb_mash_nc_stage;

  localparam int EW  = 13;
  localparam int YW  = 3;
  localparam int MOD = 1 << EW;

  logic clck = 1'b0;
  logic rst  = 1'b0;

  mash_nc_stage_if #(.EW(EW), .YW(YW)) bus0 ();
  mash_nc_stage_if #(.EW(EW), .YW(YW)) bus1 ();

  mash_nc_stage #(.EW(EW), .YW(YW), .DITHER(1'b0)) dut0 (.clck(clck), .rst(rst), .bus(bus0));
  mash_nc_stage #(.EW(EW), .YW(YW), .DITHER(1'b1)) dut1 (.clck(clck), .rst(rst), .bus(bus1));

  always #5 clck = ~clck;

  int assertCount = 0;
  int failCount   = 0;
  bit chkEn       = 1'b0;

  int          mAcc1 [2];
  int          mAcc2 [2];
  int          mC2p  [2];
  int          mY    [2];
  bit          mV    [2];
  logic [15:0] mLfsr [2];

  task automatic checkOutput(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      mAcc1[i] = 0; mAcc2[i] = 0; mC2p[i] = 0;
      mY[i] = 0; mV[i] = 1'b0; mLfsr[i] = 16'hACE1;
    end
  endfunction

  // One sample of the MASH 1-1 recurrence in plain integer arithmetic
  function automatic void modelStep(input bit en, input int y, input int e);
    int d, s1, s2, c1, c2;
    for (int i = 0; i < 2; i++) begin
      if (!en) begin
        mV[i] = 1'b0;
      end else begin
        d  = (i == 1) ? int'(mLfsr[i][0]) : 0;
        s1 = mAcc1[i] + e + d;
        c1 = (s1 >= MOD) ? 1 : 0;
        s2 = mAcc2[i] + (s1 % MOD);
        c2 = (s2 >= MOD) ? 1 : 0;
        mY[i]    = y + c1 + c2 - mC2p[i];
        mV[i]    = 1'b1;
        mAcc1[i] = s1 % MOD;
        mAcc2[i] = s2 % MOD;
        mC2p[i]  = c2;
        mLfsr[i] = {mLfsr[i][14:0], mLfsr[i][15] ^ mLfsr[i][13] ^ mLfsr[i][12] ^ mLfsr[i][10]};
      end
    end
  endfunction

  always @(negedge clck) begin
    if (chkEn) begin
      checkOutput("y_out_nodither",  int'($signed(bus0.y_out)), mY[0]);
      checkOutput("valid_nodither",  int'(bus0.valid_out),      int'(mV[0]));
      checkOutput("y_out_dither",    int'($signed(bus1.y_out)), mY[1]);
      checkOutput("valid_dither",    int'(bus1.valid_out),      int'(mV[1]));
    end
  end

  task automatic applyStimulus(input bit en, input int y, input int e);
    @(negedge clck);
    bus0.en = en; bus0.y_in = YW'(y); bus0.e_in = EW'(e);
    bus1.en = en; bus1.y_in = YW'(y); bus1.e_in = EW'(e);
    @(posedge clck);
    if (rst) modelStep(en, y, e);
    #1;
  endtask

  // Asserts reset in the middle of the high phase and checks the asynchronous clear
  task automatic pulseReset();
    @(posedge clck);
    #3;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_y0", int'($signed(bus0.y_out)), 0);
    checkOutput("async_rst_v0", int'(bus0.valid_out), 0);
    checkOutput("async_rst_y1", int'($signed(bus1.y_out)), 0);
    checkOutput("async_rst_v1", int'(bus1.valid_out), 0);
    @(posedge clck);
    #3;
    rst = 1'b1;
  endtask

  int pat [4] = '{0, 1, 1, 0};
  int yRand [10];
  int rec   [10];

  initial begin
    int v, sum, mn, mx, k;
    modelReset();
    bus0.en = 1'b0; bus0.y_in = '0; bus0.e_in = '0;
    bus1.en = 1'b0; bus1.y_in = '0; bus1.e_in = '0;
    chkEn = 1'b1;

    $display("[TB] reset hold with random inputs");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, int'($urandom_range(7)) - 4, int'($urandom_range(MOD - 1)));
      checkOutput("reset_hold_y", int'($signed(bus0.y_out)), 0);
      checkOutput("reset_hold_v", int'(bus0.valid_out), 0);
    end
    @(posedge clck); #3; rst = 1'b1;
    applyStimulus(1'b1, 0, 0);
    checkOutput("first_sample_y", int'($signed(bus0.y_out)), 0);
    checkOutput("first_sample_v", int'(bus0.valid_out), 1);

    $display("[TB] pure coarse path");
    pulseReset();
    applyStimulus(1'b1, 3, 0);
    checkOutput("coarse_pos", int'($signed(bus0.y_out)), 3);
    applyStimulus(1'b1, -4, 0);
    checkOutput("coarse_neg", int'($signed(bus0.y_out)), -4);

    $display("[TB] half residue, continuous strobe");
    pulseReset();
    sum = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 0, 4096);
      v = int'($signed(bus0.y_out));
      sum += v;
      if (i < 8) checkOutput("half_pattern", v, pat[i % 4]);
    end
    checkOutput("half_sum64", sum, 32);

    $display("[TB] range extremes");
    pulseReset();
    mn = 100; mx = -100;
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b1, 3, MOD - 1);
      v = int'($signed(bus0.y_out));
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    checkOutput("ext_min_ge2", int'(mn >= 2), 1);
    checkOutput("ext_max_le5", int'(mx <= 5), 1);
    pulseReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, -4, 0);
      if (i == 15) checkOutput("ext_const_neg4", int'($signed(bus0.y_out)), -4);
    end

    $display("[TB] strobe gating every third cycle");
    pulseReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 0, 4096);
      checkOutput("gate_pattern", int'($signed(bus0.y_out)), pat[i % 4]);
      for (int j = 0; j < 2; j++) begin
        applyStimulus(1'b0, int'($urandom_range(7)) - 4, int'($urandom_range(MOD - 1)));
        checkOutput("gate_hold", int'($signed(bus0.y_out)), pat[i % 4]);
        checkOutput("gate_valid_low", int'(bus0.valid_out), 0);
      end
    end

    $display("[TB] dither run, mid-stream reset and replay");
    pulseReset();
    for (int i = 0; i < 10; i++) begin
      yRand[i] = int'($urandom_range(7)) - 4;
      applyStimulus(1'b1, yRand[i], 4096);
      rec[i] = mY[1];
    end
    pulseReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, yRand[i], 4096);
      checkOutput("dither_replay", int'($signed(bus1.y_out)), rec[i]);
    end

    $display("[TB] random stream");
    pulseReset();
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(3));
      applyStimulus(k != 0, int'($urandom_range(7)) - 4, int'($urandom_range(MOD - 1)));
    end

    @(negedge clck);
    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
